uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, runtime baud divisor, configurable data width, optional parity and 1 or 2 stop bits. It is the next-generation TX path between the order/telemetry logic and the FPGA TX pin. Upstream logic pushes words with a ready/valid handshake. The block serialises frames back-to-back, LSB first, with no idle gap while the FIFO holds data.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame. Legal range is 5..9.
- PARITY_MODE, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame. Legal values are 1 or 2.
- FIFO_DEPTH, 4: FIFO entries. Must be a power of 2, ≥ 2.
- DIV_WIDTH, 16: width of the baud divisor.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Clks_Per_Bit  in  DIV_WIDTH  clocks per bit (D).
- i_Tx_DV  in  1  write strobe. A write occurs when i_Tx_DV and o_Tx_Ready are both high at a clock edge.
- i_Tx_Byte  in  DATA_BITS  word to transmit.
- o_Tx_Ready  out  1  FIFO not full. Combinational from the FIFO count.
- o_Tx_Serial  out  1  serial line. Registered, idles high.
- o_Tx_Active  out  1  high while a frame is on the line.
- o_Tx_Done  out  1  one-cycle pulse per completed frame.
- o_Tx_Drop  out  1  one-cycle pulse when i_Tx_DV is high while o_Tx_Ready is low.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- FIFO:
  - Circular buffer with read and write pointers that wrap at FIFO_DEPTH.
  - A write to a full FIFO is discarded and pulses o_Tx_Drop. FIFO contents are unchanged.
  - A simultaneous write and pop leaves the count unchanged. Data is still written.
- State machine: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If the FIFO is non-empty: pop the head word, latch it, latch the effective divisor, compute parity, set o_Tx_Serial to 0 and o_Tx_Active to 1, then go to START.
  - Otherwise: o_Tx_Serial = 1 and o_Tx_Active = 0.
- Effective divisor Deff = max(i_Clks_Per_Bit, 4). It is sampled only at frame start; changes mid-frame have no effect.
- Every bit is held exactly Deff cycles, counted by a bit counter from 0 to Deff-1.
- START → DATA.
- DATA drives data[idx] for idx = 0..DATA_BITS-1, then goes to PARITY if PARITY_MODE ≠ 0, else to STOP.
- PARITY drives the parity bit:
  - even mode: XOR of the data bits;
  - odd mode: the inverse of that XOR.
- STOP holds the line at 1 for STOP_BITS×Deff cycles.
- At the end of STOP:
  - Pulse o_Tx_Done.
  - If the FIFO is non-empty: pop immediately and drive the next start bit on the next cycle, so there is zero idle gap and o_Tx_Active stays high.
  - Otherwise: return to IDLE and drop o_Tx_Active.
- Frame length is (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × Deff cycles.
- Illegal parameter values are undefined; the bench does not use them.

## Timing
- Reset values: o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0, o_Tx_Drop = 0, o_Fifo_Count = 0, o_Tx_Ready = 1, state = IDLE, pointers and counters = 0.
- Reset mid-frame: on the next cycle the line is 1, the FIFO is empty, and no o_Tx_Done pulse is produced.
- Reset dominates a write in the same cycle; that write is lost.
- Latency: a write in cycle 0 into an empty, idle block gives o_Fifo_Count = 1 in cycle 1 and the start bit (line low) from cycle 2.
- o_Tx_Done is high for exactly one cycle, the cycle after the last stop-bit cycle. For back-to-back frames this coincides with the first start-bit cycle of the next frame.
- o_Tx_Ready drops in the cycle after the write that fills the FIFO. It rises in the cycle after the pop that frees an entry.

## Test plan
- 8N1, D=4, write 0xA5:
  - Line low cycles 2–5.
  - Bits 1,0,1,0,0,1,0,1 for 4 cycles each.
  - Stop high for 4 cycles.
  - One o_Tx_Done pulse. Frame is 40 cycles.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2, D=10, write 0x55: frame is 7 data bits + parity 0 + 20 cycles of stop = 110 cycles total. Odd-parity build, same data: parity bit 1.
- FIFO_DEPTH=4, D=4:
  - Write 5 words on consecutive cycles. First word pops cycle 1, so all 5 are accepted with o_Tx_Drop = 0.
  - Five frames go out with no idle gap.
  - o_Tx_Active stays high throughout. Five o_Tx_Done pulses.
- Overflow: hold D=100, push words until o_Tx_Ready = 0, then one more write → o_Tx_Drop pulses and o_Fifo_Count stays at 4. The dropped word never appears on the line.
- Divisor: i_Clks_Per_Bit = 2 gives 4-cycle bits. Changing from 8 to 16 mid-frame keeps 8-cycle bits until the next frame.
- Reset asserted during data bit 3 with 2 words queued: next cycle the line is 1, count = 0, Active = 0, and no Done pulse. After release the line stays idle.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with an integrated transmit FIFO
// Frames go out LSB first, back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [DIV_WIDTH-1:0]          i_Clks_Per_Bit,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic                          o_Tx_Drop,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DIV_WIDTH-1:0] MIN_DIV = DIV_WIDTH'(4);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DIV_WIDTH-1:0]  bit_cnt_q, bit_cnt_d, deff_q, deff_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  serial_q, serial_d;
  logic                  active_q, active_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;
  logic                  push, load, bit_end, fifo_empty;
  logic [DATA_BITS-1:0]  head;

  assign fifo_empty   = (count_q == '0);
  assign o_Tx_Ready   = (count_q != CW'(FIFO_DEPTH));
  assign push         = i_Tx_DV && o_Tx_Ready;
  assign head         = mem_q[rd_ptr_q];
  assign bit_end      = (bit_cnt_q == deff_q - DIV_WIDTH'(1));

  assign o_Tx_Serial  = serial_q;
  assign o_Tx_Active  = active_q;
  assign o_Tx_Done    = done_q;
  assign o_Tx_Drop    = drop_q;
  assign o_Fifo_Count = count_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    deff_d    = deff_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        load     = !fifo_empty;
      end
      S_START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = S_DATA;
          serial_d  = shift_q[0];
        end else begin
          bit_cnt_d = bit_cnt_q + DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (idx_q == 4'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY_MODE != 0) begin
              state_d  = S_PARITY;
              serial_d = parity_q;
            end else begin
              state_d  = S_STOP;
              serial_d = 1'b1;
            end
          end else begin
            // The line always shows shift_q[0]; shifting exposes the next bit.
            idx_d    = idx_q + 4'd1;
            shift_d  = shift_q >> 1;
            serial_d = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + DIV_WIDTH'(1);
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = S_STOP;
          serial_d  = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            done_d   = 1'b1;
            state_d  = S_IDLE;
            serial_d = 1'b1;
            active_d = 1'b0;
            load     = !fifo_empty;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Frame start from IDLE or straight out of STOP, so back-to-back frames have no gap.
    if (load) begin
      state_d   = S_START;
      bit_cnt_d = '0;
      idx_d     = '0;
      shift_d   = head;
      deff_d    = (i_Clks_Per_Bit < MIN_DIV) ? MIN_DIV : i_Clks_Per_Bit;
      parity_d  = (^head) ^ (PARITY_MODE == 1);
      serial_d  = 1'b0;
      active_d  = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(load);
    drop_d   = i_Tx_DV && !o_Tx_Ready;
    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (push && !i_Reset) begin
      mem_q[wr_ptr_q] <= i_Tx_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      bit_cnt_q <= '0;
      deff_q    <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      bit_cnt_q <= bit_cnt_d;
      deff_q    <= deff_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - bench for uart_tx_fifo: 8N1, 7E2 and 7O2 builds on shared stimulus
// A frame-level model predicts every output each cycle; directed checks pin key timings.
module tb_uart_tx_fifo;
  logic        clk;
  logic        rst;
  logic [15:0] dvsr;
  logic        dv;
  logic [7:0]  tx;

  logic [2:0]      ser, act, dne, drp, rdy;
  logic [2:0][2:0] cnt;

  int n_checks;
  int n_fails;
  logic mon_en;

  // Model state per instance
  logic [7:0] mq    [3][8];
  int         msz   [3];
  logic       mbits [3][16];
  int         mnb   [3];
  int         mpos  [3];
  int         mdeff [3];
  logic       mact  [3];
  logic       mdone [3];
  logic       mdrop [3];

  uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(dvsr), .i_Tx_DV(dv), .i_Tx_Byte(tx),
    .o_Tx_Ready(rdy[0]), .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(dne[0]),
    .o_Tx_Drop(drp[0]), .o_Fifo_Count(cnt[0]));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(dvsr), .i_Tx_DV(dv), .i_Tx_Byte(tx[6:0]),
    .o_Tx_Ready(rdy[1]), .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(dne[1]),
    .o_Tx_Drop(drp[1]), .o_Fifo_Count(cnt[1]));

  uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Clks_Per_Bit(dvsr), .i_Tx_DV(dv), .i_Tx_Byte(tx[6:0]),
    .o_Tx_Ready(rdy[2]), .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(dne[2]),
    .o_Tx_Drop(drp[2]), .o_Fifo_Count(cnt[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int db_of(input int i);
    return (i == 0) ? 8 : 7;
  endfunction
  function automatic int pm_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 2 : 1);
  endfunction
  function automatic int sb_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic check(input string nm, input int inst, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fails++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, a, e, $time);
    end
  endtask

  task automatic model_reset(input int i);
    msz[i]   = 0;
    mact[i]  = 1'b0;
    mdone[i] = 1'b0;
    mdrop[i] = 1'b0;
    mpos[i]  = 0;
    mnb[i]   = 1;
    mdeff[i] = 4;
  endtask

  task automatic start_frame(input int i);
    logic [7:0] w;
    logic p;
    int n;
    w = mq[i][0];
    for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
    msz[i]--;
    mdeff[i] = (dvsr < 16'd4) ? 4 : int'(dvsr);
    n = 0;
    mbits[i][n++] = 1'b0;
    p = 1'b0;
    for (int k = 0; k < db_of(i); k++) begin
      mbits[i][n++] = w[k];
      p ^= w[k];
    end
    if (pm_of(i) != 0) mbits[i][n++] = (pm_of(i) == 1) ? ~p : p;
    for (int k = 0; k < sb_of(i); k++) mbits[i][n++] = 1'b1;
    mnb[i]  = n;
    mpos[i] = 0;
    mact[i] = 1'b1;
  endtask

  task automatic model_step(input int i);
    logic room;
    logic [7:0] mask;
    room = (msz[i] < 4);
    if (rst) begin
      model_reset(i);
      return;
    end
    mdone[i] = 1'b0;
    if (mact[i]) begin
      mpos[i]++;
      if (mpos[i] == mnb[i] * mdeff[i]) begin
        mdone[i] = 1'b1;
        mact[i]  = 1'b0;
      end
    end
    if (!mact[i] && msz[i] > 0) start_frame(i);
    mask = (db_of(i) == 8) ? 8'hFF : 8'h7F;
    if (dv && room) begin
      mq[i][msz[i]] = tx & mask;
      msz[i]++;
    end
    mdrop[i] = dv && !room;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        check("serial", i, 32'(ser[i]), mact[i] ? 32'(mbits[i][mpos[i] / mdeff[i]]) : 32'd1);
        check("active", i, 32'(act[i]), 32'(mact[i]));
        check("done",   i, 32'(dne[i]), 32'(mdone[i]));
        check("drop",   i, 32'(drp[i]), 32'(mdrop[i]));
        check("count",  i, 32'(cnt[i]), 32'(msz[i]));
        check("ready",  i, 32'(rdy[i]), 32'(msz[i] < 4));
      end
    end
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((act != 3'b000 || cnt[0] != 3'd0 || cnt[1] != 3'd0 || cnt[2] != 3'd0) && k < 20000) begin
      tick();
      k++;
    end
    check("idle_timeout", 0, 32'(k < 20000), 32'd1);
    repeat (3) tick();
  endtask

  int acnt [3];
  int dcnt [3];
  int gap;
  int drops;
  int nw;
  logic [9:0] pat;

  initial begin
    n_checks = 0;
    n_fails  = 0;
    mon_en   = 1'b0;
    rst  = 1'b1;
    dv   = 1'b0;
    tx   = 8'h00;
    dvsr = 16'd4;
    for (int i = 0; i < 3; i++) model_reset(i);

    tick();
    mon_en = 1'b1;
    tick();
    check("rst_serial", 0, 32'(ser), 32'h7);
    check("rst_active", 0, 32'(act), 32'h0);
    check("rst_done",   0, 32'(dne), 32'h0);
    check("rst_drop",   0, 32'(drp), 32'h0);
    check("rst_ready",  0, 32'(rdy), 32'h7);
    check("rst_count",  0, 32'(cnt[0]), 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // 8N1 D=4 0xA5: start at cycle 2, 40-cycle frame, done at cycle 42
    dv = 1'b1; tx = 8'hA5;
    tick();
    dv = 1'b0;
    check("lat_count", 0, 32'(cnt[0]), 32'd1);
    check("lat_line_c1", 0, 32'(ser[0]), 32'd1);
    pat = 10'b1_10100101_0;
    acnt[0] = 0; dcnt[0] = 0;
    for (int c = 2; c < 48; c++) begin
      tick();
      if (c < 42) check("f1_line", 0, 32'(ser[0]), 32'(pat[(c - 2) / 4]));
      acnt[0] += int'(act[0]);
      if (dne[0]) begin
        dcnt[0]++;
        check("f1_done_cycle", 0, c, 42);
      end
    end
    check("f1_active_cycles", 0, acnt[0], 40);
    check("f1_done_pulses", 0, dcnt[0], 1);
    wait_idle();

    // D=10 0x55: 8N1 100 cycles, 7E2/7O2 110 cycles, parity 0 / 1
    dv = 1'b1; tx = 8'h55; dvsr = 16'd10;
    for (int i = 0; i < 3; i++) acnt[i] = 0;
    for (int c = 1; c < 126; c++) begin
      tick();
      dv = 1'b0;
      if (c == 85) begin
        check("even_parity_bit", 1, 32'(ser[1]), 32'd0);
        check("odd_parity_bit", 2, 32'(ser[2]), 32'd1);
      end
      for (int i = 0; i < 3; i++) acnt[i] += int'(act[i]);
    end
    check("f2_active_cycles", 0, acnt[0], 100);
    check("f2_active_cycles", 1, acnt[1], 110);
    check("f2_active_cycles", 2, acnt[2], 110);
    wait_idle();

    // Five words on consecutive cycles, D=4: all accepted, no idle gap
    dvsr = 16'd4;
    dv = 1'b1; tx = 8'h31;
    acnt[0] = 0; dcnt[0] = 0; dcnt[1] = 0; gap = 0; drops = 0;
    for (int c = 1; c < 231; c++) begin
      tick();
      if (c < 5) tx = 8'h31 + 8'(c);
      else dv = 1'b0;
      acnt[0] += int'(act[0]);
      if (c >= 2 && c <= 201 && !act[0]) gap++;
      dcnt[0] += int'(dne[0]);
      dcnt[1] += int'(dne[1]);
      drops += int'(drp[0]) + int'(drp[1]) + int'(drp[2]);
    end
    check("b2b_active_cycles", 0, acnt[0], 200);
    check("b2b_gap", 0, gap, 0);
    check("b2b_done_pulses", 0, dcnt[0], 5);
    check("b2b_done_pulses", 1, dcnt[1], 5);
    check("b2b_drops", 0, drops, 0);
    wait_idle();

    // Overflow at D=100: fill, then one dropped write of 0xEE
    dvsr = 16'd100;
    nw = 0;
    for (int k = 0; k < 20 && rdy[0]; k++) begin
      dv = 1'b1; tx = 8'h10 + 8'(nw);
      nw++;
      tick();
    end
    check("ovf_accepted", 0, nw, 5);
    check("ovf_ready_low", 0, 32'(rdy[0]), 32'd0);
    dv = 1'b1; tx = 8'hEE;
    tick();
    dv = 1'b0;
    check("ovf_drop", 0, 32'(drp[0]), 32'd1);
    check("ovf_drop", 2, 32'(drp[2]), 32'd1);
    check("ovf_count", 0, 32'(cnt[0]), 32'd4);
    tick();
    check("ovf_drop_pulse_end", 0, 32'(drp[0]), 32'd0);
    wait_idle();

    // D=2 clamps to 4-cycle bits
    dvsr = 16'd2;
    dv = 1'b1; tx = 8'h3C;
    acnt[0] = 0;
    for (int c = 1; c < 60; c++) begin
      tick();
      dv = 1'b0;
      acnt[0] += int'(act[0]);
    end
    check("clamp_active_cycles", 0, acnt[0], 40);
    wait_idle();

    // D changes 8 -> 16 mid-frame: frame stays at 8-cycle bits
    dvsr = 16'd8;
    dv = 1'b1; tx = 8'hC3;
    acnt[0] = 0;
    for (int c = 1; c < 100; c++) begin
      tick();
      dv = 1'b0;
      if (c == 10) dvsr = 16'd16;
      acnt[0] += int'(act[0]);
    end
    check("midchange_active_cycles", 0, acnt[0], 80);
    wait_idle();

    // Reset during data bit 3 with two words queued
    dvsr = 16'd4;
    dv = 1'b1; tx = 8'h0F;
    for (int c = 1; c < 20; c++) begin
      tick();
      if (c == 1) tx = 8'hF0;
      else if (c == 2) tx = 8'h5A;
      else dv = 1'b0;
      if (c == 19) rst = 1'b1;
    end
    tick();
    rst = 1'b0;
    check("mrst_line", 0, 32'(ser), 32'h7);
    check("mrst_count", 0, 32'(cnt[0]), 32'd0);
    check("mrst_active", 0, 32'(act), 32'h0);
    check("mrst_done", 0, 32'(dne), 32'h0);
    dcnt[0] = 0; gap = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (ser != 3'b111 || act != 3'b000) gap++;
      dcnt[0] += int'(dne[0]) + int'(dne[1]) + int'(dne[2]);
    end
    check("mrst_stays_idle", 0, gap, 0);
    check("mrst_no_done", 0, dcnt[0], 0);

    // Reset dominates a write in the same cycle
    rst = 1'b1; dv = 1'b1; tx = 8'h99;
    tick();
    rst = 1'b0; dv = 1'b0;
    check("rst_write_lost", 0, 32'(cnt[0]), 32'd0);
    repeat (3) tick();
    check("rst_write_line", 0, 32'(ser), 32'h7);
    check("rst_write_active", 0, 32'(act), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
